// File: rtl/call_ret_seq.sv
// call_ret_seq: bit-serial return-stack call/return sequencer; define CALL_STACK_WRAP_EN to let full-stack calls overwrite the oldest entry
module call_ret_seq #(
  parameter int PC_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            call,
  input  logic            ret_req,
  input  logic [PC_W-1:0] pc_in,
  input  logic            flag_clr,
  output logic            busy,
  output logic            done,
  output logic [PC_W-1:0] pc_out,
  output logic            pc_valid,
  output logic            ovf,
  output logic            unf,
  output logic            stk_in,
  output logic            stk_push,
  output logic            stk_pop,
  input  logic            stk_bit
);
  localparam int KW = $clog2(2 * PC_W);
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [KW-1:0] K_LAST = KW'(2 * PC_W - 1);
  localparam logic [LW-1:0] L_MAX = LW'(DEPTH);
`ifdef CALL_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, PUSH, POP, DONE} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [PC_W-1:0] pc_lat_q, pc_lat_d, shift_q, shift_d, pc_out_q, pc_out_d;
  logic busy_q, busy_d, done_q, done_d, pc_valid_q, pc_valid_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic stk_in_q, stk_in_d, stk_push_q, stk_push_d, stk_pop_q, stk_pop_d;
  logic set_ovf, set_unf, full;
  logic [KW-2:0] pidx, half_d;
  assign full   = lvl_q == L_MAX;
  assign pidx   = (KW-1)'(PC_W - 1) - k_q[KW-1:1];
  assign half_d = k_d[KW-1:1];
  // Next-state logic; strobes and status are derived from the next state so every output is a flop
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    lvl_d      = lvl_q;
    pc_lat_d   = pc_lat_q;
    shift_d    = shift_q;
    pc_out_d   = pc_out_q;
    pc_valid_d = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (state_q == IDLE || state_q == DONE) begin
      state_d = IDLE;
      k_d     = '0;
      if (call) begin
        set_ovf  = full;
        state_d  = (!full || WRAP) ? PUSH : DONE;
        pc_lat_d = (!full || WRAP) ? pc_in : pc_lat_q;
      end else if (ret_req) begin
        set_unf = lvl_q == '0;
        state_d = set_unf ? DONE : POP;
      end
    end else begin
      k_d = k_q + 1'b1;
      if (state_q == POP && k_q[0]) shift_d[pidx] = stk_bit;
      if (k_q == K_LAST) begin
        state_d = DONE;
        k_d     = '0;
        if (state_q == PUSH) begin
          lvl_d = full ? lvl_q : lvl_q + 1'b1;
        end else begin
          lvl_d      = lvl_q - 1'b1;
          pc_out_d   = shift_d;
          pc_valid_d = 1'b1;
        end
      end
    end
    busy_d     = state_d == PUSH || state_d == POP;
    done_d     = state_d == DONE;
    stk_push_d = state_d == PUSH && !k_d[0];
    stk_pop_d  = state_d == POP && !k_d[0];
    stk_in_d   = stk_push_d ? pc_lat_d[half_d] : stk_in_q;
    ovf_d      = set_ovf | (ovf_q & ~flag_clr);
    unf_d      = set_unf | (unf_q & ~flag_clr);
  end
  // State and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      lvl_q      <= '0;
      pc_lat_q   <= '0;
      shift_q    <= '0;
      pc_out_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pc_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      stk_in_q   <= 1'b0;
      stk_push_q <= 1'b0;
      stk_pop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      lvl_q      <= lvl_d;
      pc_lat_q   <= pc_lat_d;
      shift_q    <= shift_d;
      pc_out_q   <= pc_out_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pc_valid_q <= pc_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      stk_in_q   <= stk_in_d;
      stk_push_q <= stk_push_d;
      stk_pop_q  <= stk_pop_d;
    end
  end
  assign busy     = busy_q;
  assign done     = done_q;
  assign pc_out   = pc_out_q;
  assign pc_valid = pc_valid_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign stk_in   = stk_in_q;
  assign stk_push = stk_push_q;
  assign stk_pop  = stk_pop_q;
endmodule

// File: tb/tb_call_ret_seq.sv
// tb_call_ret_seq: transaction-level model, bit-serial stack model and directed checks for call_ret_seq
module tb_call_ret_seq;
  localparam int P = 4;
  localparam int D = 4;
`ifdef CALL_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic clk = 0, rst = 1, call = 0, ret_req = 0, flag_clr = 0, stk_bit = 0;
  logic [P-1:0] pc_in = '0;
  logic busy, done, pc_valid, ovf, unf, stk_in, stk_push, stk_pop;
  logic [P-1:0] pc_out;
  int errors = 0, checks = 0;

  call_ret_seq #(.PC_W(P), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .call(call), .ret_req(ret_req), .pc_in(pc_in),
    .flag_clr(flag_clr), .busy(busy), .done(done), .pc_out(pc_out),
    .pc_valid(pc_valid), .ovf(ovf), .unf(unf), .stk_in(stk_in),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_bit(stk_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // External bit-serial LIFO: reacts to strobe rising edges, logs pushed bits
  logic bq[$];
  logic bits_log[$];
  logic prev_push = 0, prev_pop = 0;
  int push_cnt = 0, pop_cnt = 0;
  always @(negedge clk) begin
    if (stk_push === 1'b1 && !prev_push) begin
      bq.push_front(stk_in);
      if (bq.size() > D * P) void'(bq.pop_back());
      bits_log.push_back(stk_in);
      push_cnt++;
    end
    if (stk_pop === 1'b1 && !prev_pop) begin
      stk_bit = bq.size() > 0 ? bq.pop_front() : 1'b0;
      pop_cnt++;
    end
    prev_push = stk_push === 1'b1;
    prev_pop  = stk_pop === 1'b1;
  end

  // Transaction model: m_n is the position of the coming cycle relative to the accepting edge
  logic [P-1:0] mstk[$];
  int m_n = 0;
  bit mv = 0, m_rej = 0, m_op = 0, m_ovf = 0, m_unf = 0, n_ovf, n_unf;
  logic [P-1:0] m_lat = '0, m_pc_out = '0;
  always @(posedge clk) begin
    mv = 1;
    if (rst) begin
      m_n = 0; mstk.delete(); m_ovf = 0; m_unf = 0; m_pc_out = '0; m_rej = 0; m_op = 0;
    end else begin
      n_ovf = m_ovf & ~flag_clr;
      n_unf = m_unf & ~flag_clr;
      m_rej = 0;
      if (m_n == 0 || m_n == 2 * P + 1) begin
        m_n = 0;
        if (call) begin
          if (mstk.size() == D) n_ovf = 1;
          if (mstk.size() < D || WRAP) begin m_op = 1; m_lat = pc_in; m_n = 1; end
          else m_rej = 1;
        end else if (ret_req) begin
          if (mstk.size() > 0) begin m_op = 0; m_n = 1; end
          else begin n_unf = 1; m_rej = 1; end
        end
      end else begin
        m_n++;
        if (m_n == 2 * P + 1) begin
          if (m_op) begin
            mstk.push_front(m_lat);
            if (mstk.size() > D) void'(mstk.pop_back());
          end else m_pc_out = mstk.pop_front();
        end
      end
      m_ovf = n_ovf;
      m_unf = n_unf;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (mv) begin
      automatic bit xfer = m_n >= 1 && m_n <= 2 * P;
      automatic bit strobe = xfer && (m_n % 2 == 1);
      chk("busy", busy, xfer);
      chk("done", done, m_n == 2 * P + 1 || m_rej);
      chk("pc_valid", pc_valid, m_n == 2 * P + 1 && !m_op);
      chk("pc_out", pc_out, m_pc_out);
      chk("ovf", ovf, m_ovf);
      chk("unf", unf, m_unf);
      chk("stk_push", stk_push, strobe && m_op);
      chk("stk_pop", stk_pop, strobe && !m_op);
      if (strobe && m_op) chk("stk_in", stk_in, m_lat[(m_n - 1) / 2]);
    end
  end

  task automatic req(input logic c, input logic r, input logic [P-1:0] pc, output int lat);
    call = c; ret_req = r; pc_in = pc; lat = 0;
    do begin
      @(negedge clk);
      call = 0; ret_req = 0; flag_clr = 0; lat++;
    end while (!done && lat < 20);
  endtask

  initial begin
    int lat, p0, q0;
    int exp_bits[4] = '{1, 1, 0, 1};
    logic [P-1:0] exp_pops[4];
    exp_pops = WRAP ? '{4'h5, 4'h4, 4'h3, 4'h2} : '{4'h4, 4'h3, 4'h2, 4'h1};
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pc_out", pc_out, 0);
    chk("rst_strobes", {stk_push, stk_pop, stk_in}, 0);
    rst = 0;
    @(negedge clk);
    // call 4'hB: LSB-first bits 1,1,0,1 on four push strobes, 9-cycle latency
    p0 = push_cnt;
    req(1, 0, 4'hB, lat);
    chk("call_B_lat", lat, 9);
    chk("call_B_pushes", push_cnt - p0, 4);
    for (int i = 0; i < 4; i++) chk("call_B_bit", bits_log[bits_log.size() - 4 + i], exp_bits[i]);
    req(1, 0, 4'h6, lat);
    chk("call_6_lat", lat, 9);
    req(0, 1, 4'h0, lat);
    chk("ret1_lat", lat, 9); chk("ret1_pc", pc_out, 4'h6); chk("ret1_valid", pc_valid, 1);
    req(0, 1, 4'h0, lat);
    chk("ret2_lat", lat, 9); chk("ret2_pc", pc_out, 4'hB); chk("ret2_valid", pc_valid, 1);
    // underflow at empty stack
    q0 = pop_cnt;
    req(0, 1, 4'h0, lat);
    chk("unf_lat", lat, 1); chk("unf_set", unf, 1); chk("unf_pc_hold", pc_out, 4'hB);
    chk("unf_valid", pc_valid, 0); chk("unf_no_pop", pop_cnt - q0, 0);
    flag_clr = 1; @(negedge clk); flag_clr = 0;
    chk("unf_clr", unf, 0);
    flag_clr = 1;
    req(0, 1, 4'h0, lat);
    chk("unf_set_wins", unf, 1);
    flag_clr = 1; @(negedge clk); flag_clr = 0;
    // fill the stack, then one call too many
    for (int i = 1; i <= 4; i++) begin
      req(1, 0, P'(i), lat);
      chk("fill_lat", lat, 9);
    end
    p0 = push_cnt;
    req(1, 0, 4'h5, lat);
    chk("ovf_set", ovf, 1);
    chk("ovf_lat", lat, WRAP ? 9 : 1);
    chk("ovf_pushes", push_cnt - p0, WRAP ? 4 : 0);
    for (int i = 0; i < 4; i++) begin
      req(0, 1, 4'h0, lat);
      chk("drain_pc", pc_out, exp_pops[i]);
    end
    req(0, 1, 4'h0, lat);
    chk("drain_unf", unf, 1);
    flag_clr = 1; @(negedge clk); flag_clr = 0;
    chk("flags_clr", {ovf, unf}, 0);
    // simultaneous call and ret_req: call wins
    req(1, 0, 4'h9, lat);
    p0 = push_cnt; q0 = pop_cnt;
    req(1, 1, 4'hA, lat);
    chk("both_lat", lat, 9); chk("both_pushes", push_cnt - p0, 4); chk("both_no_pop", pop_cnt - q0, 0);
    // ret_req while busy is ignored
    call = 1; pc_in = 4'h3;
    @(negedge clk); call = 0; ret_req = 1;
    @(negedge clk); ret_req = 0;
    lat = 2;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    chk("busy_ret_lat", lat, 9);
    repeat (2) @(negedge clk);
    chk("busy_ret_dropped", busy, 0); chk("busy_ret_no_pop", pop_cnt - q0, 0);
    // reset in the middle of a return
    ret_req = 1;
    @(negedge clk); ret_req = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("rst_mid_busy", busy, 0); chk("rst_mid_pop", stk_pop, 0); chk("rst_mid_valid", pc_valid, 0);
    repeat (10) @(negedge clk);
    req(0, 1, 4'h0, lat);
    chk("rst_mid_unf_lat", lat, 1); chk("rst_mid_unf", unf, 1);
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
